vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with a registered, blanked RGB565 output stage.
// Optional macro VGA_PREFETCH_EN registers pixel_req/xpos/ypos one position ahead for a synchronous-read renderer.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pixel_data,
  output logic        pixel_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);
  localparam logic [10:0] H_LAST     = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [10:0] V_LAST     = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] H_START    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END      = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_START    = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END      = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic        SYNC_ACT   = (SYNC_POL != 0);

  function automatic logic [10:0] h_next(input logic [10:0] h);
    return (h == H_LAST) ? 11'd0 : h + 11'd1;
  endfunction

  // The line counter only moves on the cycle the pixel counter wraps.
  function automatic logic [10:0] v_next(input logic [10:0] h, input logic [10:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? 11'd0 : v + 11'd1;
  endfunction

  function automatic logic in_disp(input logic [10:0] h, input logic [10:0] v);
    return (h >= H_START) && (h < H_END) && (v >= V_START) && (v < V_END);
  endfunction

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        hs_raw, vs_raw, de_raw;
  logic        hs_q, vs_q, de_q, fs_q;
  logic [15:0] rgb_q;

  always_comb begin
    hcnt_d = h_next(hcnt_q);
    vcnt_d = v_next(hcnt_q, vcnt_q);
    hs_raw = (hcnt_q < H_SYNC_END);
    vs_raw = (vcnt_q < V_SYNC_END);
    de_raw = in_disp(hcnt_q, vcnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= 11'd0;
      vcnt_q <= 11'd0;
      hs_q   <= ~SYNC_ACT;
      vs_q   <= ~SYNC_ACT;
      de_q   <= 1'b0;
      rgb_q  <= 16'h0000;
      fs_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_raw ? SYNC_ACT : ~SYNC_ACT;
      vs_q   <= vs_raw ? SYNC_ACT : ~SYNC_ACT;
      de_q   <= de_raw;
      rgb_q  <= de_raw ? pixel_data : 16'h0000;
      fs_q   <= (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;
  assign frame_start = fs_q;

`ifdef VGA_PREFETCH_EN
  // After this edge the counter sits at (hcnt_d, vcnt_d); the request must already describe the position after that.
  logic [10:0] ahead_h_d, ahead_v_d;
  logic        ahead_de_d;
  logic        req_q;
  logic [10:0] xpos_q, ypos_q;

  always_comb begin
    ahead_h_d  = h_next(hcnt_d);
    ahead_v_d  = v_next(hcnt_d, vcnt_d);
    ahead_de_d = in_disp(ahead_h_d, ahead_v_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      xpos_q <= 11'd0;
      ypos_q <= 11'd0;
    end else begin
      req_q  <= ahead_de_d;
      xpos_q <= ahead_de_d ? ahead_h_d - H_START : 11'd0;
      ypos_q <= ahead_de_d ? ahead_v_d - V_START : 11'd0;
    end
  end

  assign pixel_req  = req_q;
  assign pixel_xpos = xpos_q;
  assign pixel_ypos = ypos_q;
`else
  assign pixel_req  = de_raw;
  assign pixel_xpos = de_raw ? hcnt_q - H_START : 11'd0;
  assign pixel_ypos = de_raw ? vcnt_q - V_START : 11'd0;
`endif

endmodule
